// File: rtl/vrf_noc_pkg.sv
// Shared definitions for the VRF network ingress/egress blocks: default
// widths agreed with the VRF arbiter, header field placement and the
// deserializer state encoding.
package vrf_noc_pkg;

   localparam int NOC_ADDR_WIDTH  = 10;
   localparam int NOC_DATA_WIDTH  = 1024;
   localparam int NOC_FLIT_WIDTH  = 256;

   // Destination VRF row sits in the least significant bits of a header flit.
   localparam int NOC_HDR_DST_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2
   } flit_state_t;

   // Width of a counter that indexes 0..beats-1, never narrower than one bit.
   function automatic int beat_cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/vrf_flit_deserializer.sv
// Collects one header flit plus BEATS payload flits from the router ejection
// port into a full VRF row, then presents it to the VRF arbiter as a single
// write request that is held until granted.
//
// Handshakes:
//   Flit side: a flit transfers on a rising clk edge where in_flit_valid and
//   in_flit_ready are both high. in_flit_ready depends only on state and reset,
//   never on in_flit_valid, so a sender may hold valid across stalls.
//   Arbiter side: write_req rises with dst_addr/data_arbiter_recv valid and
//   holds them unchanged until the edge that samples write_gnt high; write_gnt
//   seen while write_req is low has no effect.
module vrf_flit_deserializer #(
   parameter int VRF_ADDR_WIDTH = vrf_noc_pkg::NOC_ADDR_WIDTH,
   parameter int VRF_DATA_WIDTH = vrf_noc_pkg::NOC_DATA_WIDTH,
   parameter int FLIT_WIDTH     = vrf_noc_pkg::NOC_FLIT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_flit_valid,
   output logic                      in_flit_ready,
   input  logic                      in_flit_head,
   input  logic [FLIT_WIDTH-1:0]     in_flit_data,
   output logic [VRF_ADDR_WIDTH-1:0] dst_addr,
   output logic [VRF_DATA_WIDTH-1:0] data_arbiter_recv,
   output logic                      write_req,
   input  logic                      write_gnt,
   output logic                      pkt_done,
   output logic                      pkt_err,
   output logic [15:0]               pkt_count
);
   import vrf_noc_pkg::*;

   localparam int BEATS = VRF_DATA_WIDTH / FLIT_WIDTH;
   localparam int CNT_W = beat_cnt_width(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   // Visible FSM state; checkers and debug probes bind to this signal.
   flit_state_t      state;
   logic [CNT_W-1:0] beat_cnt;
   logic             accept;

   // Ready is the only combinational output: open in IDLE/COLLECT, closed
   // while a write is pending and while reset is held.
   assign in_flit_ready = rst_n && (state != ST_WRITE);
   assign accept        = in_flit_valid && in_flit_ready;

   // Packet framing FSM, row assembly and arbiter request, all registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= ST_IDLE;
         beat_cnt          <= '0;
         write_req         <= 1'b0;
         dst_addr          <= '0;
         data_arbiter_recv <= '0;
         pkt_done          <= 1'b0;
         pkt_err           <= 1'b0;
         pkt_count         <= '0;
      end else begin
         pkt_done <= 1'b0;
         pkt_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (in_flit_head) begin
                     dst_addr <= in_flit_data[NOC_HDR_DST_LSB +: VRF_ADDR_WIDTH];
                     beat_cnt <= '0;
                     state    <= ST_COLLECT;
                  end else begin
                     // Payload without a header has no destination: drop it.
                     pkt_err <= 1'b1;
                  end
               end
            end
            ST_COLLECT: begin
               if (accept) begin
                  if (in_flit_head) begin
                     // New header restarts framing; every slot is rewritten
                     // before the next write, so stale beats never escape.
                     pkt_err  <= 1'b1;
                     dst_addr <= in_flit_data[NOC_HDR_DST_LSB +: VRF_ADDR_WIDTH];
                     beat_cnt <= '0;
                  end else begin
                     for (int b = 0; b < BEATS; b++) begin
                        if (beat_cnt == CNT_W'(b)) begin
                           data_arbiter_recv[b*FLIT_WIDTH +: FLIT_WIDTH] <= in_flit_data;
                        end
                     end
                     if (beat_cnt == LAST_BEAT) begin
                        beat_cnt  <= '0;
                        write_req <= 1'b1;
                        state     <= ST_WRITE;
                     end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                     end
                  end
               end
            end
            ST_WRITE: begin
               if (write_gnt) begin
                  write_req <= 1'b0;
                  pkt_done  <= 1'b1;
                  pkt_count <= pkt_count + 16'd1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               beat_cnt  <= '0;
               write_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/vrf_flit_deserializer.md
Name: vrf_flit_deserializer

Overview:
- Ingress stage between the router's local ejection port and the VRF arbiter write port.
- Accepts a header flit carrying the destination VRF row, then VRF_DATA_WIDTH/FLIT_WIDTH payload flits, and assembles them into one full row.
- Issues a single write_req/dst_addr/data_arbiter_recv transaction and holds it until write_gnt.
- Back-pressures the router with in_flit_ready while a write is pending.

Parameters:
- VRF_ADDR_WIDTH, 10, VRF row address width; must match the arbiter.
- VRF_DATA_WIDTH, 1024, VRF row width; must match the arbiter.
- FLIT_WIDTH, 256, router flit width; must divide VRF_DATA_WIDTH exactly.
- BEATS, VRF_DATA_WIDTH/FLIT_WIDTH, localparam; payload flits per row (4 by default).

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, synchronous, active-low
- in_flit_valid  in  1  router flit valid
- in_flit_ready  out  1  flit accepted on a cycle where valid&ready
- in_flit_head  in  1  flit is a header; dst row is in data[VRF_ADDR_WIDTH-1:0]
- in_flit_data  in  FLIT_WIDTH  flit payload
- dst_addr  out  VRF_ADDR_WIDTH  write row address to arbiter
- data_arbiter_recv  out  VRF_DATA_WIDTH  assembled row to arbiter
- write_req  out  1  write request to arbiter
- write_gnt  in  1  arbiter grant, one-cycle pulse
- pkt_done  out  1  one-cycle pulse per completed write
- pkt_err  out  1  one-cycle pulse per framing error
- pkt_count  out  16  completed writes, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, beat counter 0, write_req 0, dst_addr 0, data_arbiter_recv 0, pkt_done 0, pkt_err 0, pkt_count 0. in_flit_ready is 0 while rst_n is low.
- Reset mid-packet or mid-write drops the partial row and the pending request. No write is issued for it.
- All outputs are registered except in_flit_ready, which decodes state combinationally: 1 in IDLE and COLLECT, 0 in WRITE.
- IDLE:
  - Accepted head flit: latch dst_addr, clear beat counter, go to COLLECT.
  - Accepted non-head flit: drop it, pulse pkt_err, stay in IDLE.
- COLLECT:
  - Accepted non-head flit k (k = counter): store in data_arbiter_recv[k*FLIT_WIDTH +: FLIT_WIDTH], then increment the counter.
  - Gaps (valid low) are allowed and hold state.
  - Beat BEATS-1 accepted: go to WRITE with write_req=1 on the next cycle.
  - Accepted head flit: discard the partial row, pulse pkt_err, latch the new dst_addr, clear the counter, stay in COLLECT. Restart semantics; stale beats are never written.
- WRITE:
  - write_req=1. dst_addr and data_arbiter_recv are stable until grant.
  - Clock edge with write_gnt=1: write_req=0, pkt_done=1, pkt_count+1, state IDLE next cycle.
  - write_gnt while write_req=0 is ignored.
- Minimum latency:
  - Head accepted at cycle t, beats at t+1..t+BEATS, write_req high at t+BEATS+1.
  - Grant in that same cycle gives pkt_done at t+BEATS+2, and the next head is accepted at t+BEATS+2.
- Counter width is clog2(BEATS), minimum 1. It never exceeds BEATS-1.
- pkt_done and pkt_err are never asserted for more than one cycle per event. Both may assert together only if a reset-free sequence makes that happen, which the design cannot.

Decomposition:
- Shared package vrf_noc_pkg holds:
  - VRF_ADDR_WIDTH and VRF_DATA_WIDTH defaults, shared with the arbiter.
  - FLIT_WIDTH and the header field position (dst row at LSBs).
  - State encoding IDLE/COLLECT/WRITE.
- No sub-module. The beat write into the row register is a simple indexed part-select inside this block.
- The matching egress block (arbiter read to flits) reuses the package.

Test Plan:
- Head with dst=0x05, then beats 0xA..A, 0xB..B, 0xC..C, 0xD..D back-to-back; grant same cycle as req -> write_req high exactly 1 cycle with dst_addr=0x05, data bits[255:0]=A.., [1023:768]=D..; pkt_done pulse; pkt_count=1.
- Same packet but write_gnt delayed 7 cycles with valid held high -> in_flit_ready=0 for all 7+1 cycles; dst_addr and data stable; write_req deasserts the cycle after gnt.
- Payload flit in IDLE -> pkt_err pulse, ready stays 1, no write_req; a following good packet to dst=0x3FF writes correctly.
- Head dst=0x10, 2 beats, then head dst=0x20 and 4 beats -> one pkt_err; a single write to 0x20 containing only the new beats.
- rst_n low for 1 cycle after 3 beats -> all outputs 0, no write_req; the next full packet writes normally with pkt_count=1.
- Preload pkt_count to 0xFFFF via 65535 packets (or force) -> next completion wraps to 0x0000.
